// File: rtl/vram_pkg.sv
// Shared types and constants for the VRAM port arbiter.
// Grant codes: display port is 2'b10, DMA port is 2'b01.
package vram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_DISP = 2'b10;
    localparam logic [1:0] GRANT_DMA  = 2'b01;

    localparam int          DISPLAY_BURST = 8;
    localparam logic [31:0] FRAME_SIZE    = 32'h00096000;

    // DMA wins when the display is quiet or the DMA has waited too long.
    function automatic logic dma_wins(
        input logic dma_req,
        input logic disp_req,
        input logic starved
    );
        return dma_req && (!disp_req || starved);
    endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating wait counter for the low-priority port.
// Clear has priority over increment.
module arb_starve_counter #(
    parameter int LIMIT = 64,
    parameter int W     = $clog2(LIMIT + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         hit
);

    assign hit = (count >= W'(LIMIT));

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !hit) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/vram_port_arbiter.sv
// Two-port arbiter in front of the SDRAM Avalon-MM port.
// One transaction in flight; grant held until the last read beat.
module vram_port_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int BURST_W      = 5,
    parameter int STARVE_LIMIT = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  m0_address,
    input  logic [BURST_W-1:0] m0_burstcount,
    input  logic               m0_read,
    output logic [DATA_W-1:0]  m0_readdata,
    output logic               m0_readdatavalid,
    output logic               m0_waitrequest,
    input  logic [ADDR_W-1:0]  m1_address,
    input  logic [BURST_W-1:0] m1_burstcount,
    input  logic               m1_read,
    input  logic               m1_write,
    input  logic [DATA_W-1:0]  m1_writedata,
    output logic [DATA_W-1:0]  m1_readdata,
    output logic               m1_readdatavalid,
    output logic               m1_waitrequest,
    output logic [ADDR_W-1:0]  s_address,
    output logic [BURST_W-1:0] s_burstcount,
    output logic               s_read,
    output logic               s_write,
    output logic [DATA_W-1:0]  s_writedata,
    input  logic [DATA_W-1:0]  s_readdata,
    input  logic               s_readdatavalid,
    input  logic               s_waitrequest,
    output logic [1:0]         grant,
    output logic               busy
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    state_t             state;
    logic [BURST_W-1:0] beats;
    logic [SW-1:0]      starve_count;
    logic               starved;
    logic               m1_req;
    logic               pick_dma;
    logic               pick_disp;
    logic               accept;
    logic               starve_inc;
    logic               starve_clr;

    assign m1_req    = m1_read | m1_write;
    assign pick_dma  = dma_wins(m1_req, m0_read, starved);
    assign pick_disp = !pick_dma && m0_read;
    assign accept    = (state == CMD) && !s_waitrequest;

    assign starve_inc = m1_req && (grant != GRANT_DMA);
    assign starve_clr = (state == IDLE) && pick_dma;

    arb_starve_counter #(
        .LIMIT (STARVE_LIMIT),
        .W     (SW)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .inc   (starve_inc),
        .clr   (starve_clr),
        .count (starve_count),
        .hit   (starved)
    );

    assign busy = (state != IDLE);

    assign m0_readdata = s_readdata;
    assign m1_readdata = s_readdata;

    // Valid/stall are masked during reset so stale beats never leak out.
    assign m0_readdatavalid = reset && s_readdatavalid && (grant == GRANT_DISP);
    assign m1_readdatavalid = reset && s_readdatavalid && (grant == GRANT_DMA);
    assign m0_waitrequest   = !(reset && accept && (grant == GRANT_DISP));
    assign m1_waitrequest   = !(reset && accept && (grant == GRANT_DMA));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            grant        <= GRANT_NONE;
            beats        <= '0;
            s_read       <= 1'b0;
            s_write      <= 1'b0;
            s_address    <= '0;
            s_burstcount <= '0;
            s_writedata  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_dma) begin
                        s_address   <= m1_address;
                        s_writedata <= m1_writedata;
                        s_read      <= m1_read;
                        s_write     <= !m1_read;
                        if (!m1_read || m1_burstcount == '0) begin
                            s_burstcount <= BURST_W'(1);
                        end else begin
                            s_burstcount <= m1_burstcount;
                        end
                        grant <= GRANT_DMA;
                        state <= CMD;
                    end else if (pick_disp) begin
                        s_address   <= m0_address;
                        s_writedata <= '0;
                        s_read      <= 1'b1;
                        s_write     <= 1'b0;
                        if (m0_burstcount == '0) begin
                            s_burstcount <= BURST_W'(1);
                        end else begin
                            s_burstcount <= m0_burstcount;
                        end
                        grant <= GRANT_DISP;
                        state <= CMD;
                    end
                end
                CMD: begin
                    if (!s_waitrequest) begin
                        s_read  <= 1'b0;
                        s_write <= 1'b0;
                        if (s_read) begin
                            beats <= s_burstcount;
                            state <= DATA;
                        end else begin
                            grant <= GRANT_NONE;
                            state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (s_readdatavalid) begin
                        beats <= beats - 1'b1;
                        if (beats == BURST_W'(1)) begin
                            grant <= GRANT_NONE;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    grant <= GRANT_NONE;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
